// File: rtl/trade_decision_multi.sv
// trade_decision_multi: trade-decision engine with an N_SYM-slot position table.
// Accepts one market/confirm message per valid/ready handshake and returns one
// trade word (buy, sell or all-zero) per message over valid/yumi.
// Optional feature macro: TRADE_DEC_POS_LIMIT_EN -- caps buy size and confirmed
// positions at POS_LIMIT instead of the POS_W maximum.
module trade_decision_multi #(
    parameter int N_SYM     = 4,
    parameter int PX_W      = 64,
    parameter int THRESH    = 5,
    parameter int POS_W     = 8,
    parameter int POS_LIMIT = 200,
    localparam int MSG_W    = 2 + 32 + 2 * PX_W + 16,
    localparam int OCC_W    = $clog2(N_SYM + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [MSG_W-1:0] message_i,
    input  logic [PX_W-1:0]  average_i,
    input  logic             v_i,
    output logic             ready_o,
    input  logic             yumi_i,
    output logic             v_o,
    output logic [MSG_W-1:0] trade_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             overflow_o
);

    localparam int IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    // Two extra bits so qty + OfferSize never wraps and the MSB is a clean sign bit.
    localparam int QW    = POS_W + 2;
    localparam logic [PX_W-1:0] THRESH_PX = PX_W'(THRESH);
    localparam logic [PX_W-1:0] SELL_CAP  = {PX_W{1'b1}} - THRESH_PX;
`ifdef TRADE_DEC_POS_LIMIT_EN
    localparam logic [QW-1:0] QTY_MAX = QW'(POS_LIMIT);
`else
    localparam logic [QW-1:0] QTY_MAX = QW'({POS_W{1'b1}});
`endif

    typedef enum logic [1:0] {ST_WAIT, ST_LOOKUP, ST_DECIDE, ST_DONE} state_t;

    state_t r_state, w_next;

    logic [MSG_W-1:0] r_msg;
    logic [PX_W-1:0]  r_avg;
    logic             r_hit, r_has_free, r_ovf;
    logic [IDX_W-1:0] r_hit_idx, r_free_idx;
    logic [MSG_W-1:0] r_trade;
    logic [N_SYM-1:0] r_valid;
    logic [31:0]      r_sym [N_SYM];
    logic [POS_W-1:0] r_qty [N_SYM];

    // Fields of the latched message.
    logic [1:0]      w_type;
    logic [31:0]     w_sym;
    logic [PX_W-1:0] w_bid_px, w_off_px, w_buy_th, w_sell_th;
    logic [7:0]      w_bid_sz, w_off_sz;

    assign w_type   = r_msg[MSG_W-1 -: 2];
    assign w_sym    = r_msg[MSG_W-3 -: 32];
    assign w_bid_px = r_msg[2*PX_W+15 -: PX_W];
    assign w_bid_sz = r_msg[PX_W+15 -: 8];
    assign w_off_px = r_msg[PX_W+7 -: PX_W];
    assign w_off_sz = r_msg[7:0];

    // Saturating thresholds around the latched average.
    assign w_buy_th  = (r_avg < THRESH_PX) ? '0 : r_avg - THRESH_PX;
    assign w_sell_th = (r_avg > SELL_CAP) ? {PX_W{1'b1}} : r_avg + THRESH_PX;

    logic             w_hit, w_has_free;
    logic [IDX_W-1:0] w_hit_idx, w_free_idx;
    logic [POS_W-1:0] w_qty, w_qty_new;
    logic [QW-1:0]    w_sum;
    logic             w_underflow;
    logic [7:0]       w_sell_sz, w_buy_sz;
    logic             w_buy_ok;
    logic [MSG_W-1:0] w_trade;
    logic             w_wr_en, w_drop, w_set_ovf;
    logic [IDX_W-1:0] w_wr_idx;
    logic [OCC_W-1:0] w_occ;

    // State register; reset aborts any in-flight message at once.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= ST_WAIT;
        else            r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next  = r_state;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (r_state)
            ST_WAIT: begin
                ready_o = 1'b1;
                if (v_i) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: w_next = ST_DECIDE;
            ST_DECIDE: w_next = ST_DONE;
            ST_DONE: begin
                v_o = 1'b1;
                if (yumi_i) w_next = ST_WAIT;
            end
            default: w_next = ST_WAIT;
        endcase
    end

    // Capture message and average on the accepting edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_msg <= '0;
            r_avg <= '0;
        end else if (r_state == ST_WAIT && v_i) begin
            r_msg <= message_i;
            r_avg <= average_i;
        end
    end

    // Parallel symbol compare; descending scan leaves the lowest free index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = N_SYM - 1; i >= 0; i--) begin
            if (r_valid[i] && r_sym[i] == w_sym) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Register the lookup result for the decide step.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_has_free <= 1'b0;
            r_free_idx <= '0;
        end else if (r_state == ST_LOOKUP) begin
            r_hit      <= w_hit;
            r_hit_idx  <= w_hit_idx;
            r_has_free <= w_has_free;
            r_free_idx <= w_free_idx;
        end
    end

    // Position arithmetic: new quantity after a confirm, clamped and saturated.
    always_comb begin
        w_qty       = r_hit ? r_qty[r_hit_idx] : '0;
        w_sum       = QW'(w_qty) + QW'(w_off_sz) - QW'(w_bid_sz);
        w_underflow = w_sum[QW-1];
        if (w_underflow)          w_qty_new = '0;
        else if (w_sum > QTY_MAX) w_qty_new = QTY_MAX[POS_W-1:0];
        else                      w_qty_new = w_sum[POS_W-1:0];
    end

    // Trade sizes; the buy size is bounded by remaining room only with the limit feature.
    always_comb begin
        w_sell_sz = (w_qty < POS_W'(w_off_sz)) ? w_qty[7:0] : w_off_sz;
`ifdef TRADE_DEC_POS_LIMIT_EN
        begin
            logic [POS_W-1:0] w_room;
            w_room   = (w_qty >= POS_W'(POS_LIMIT)) ? '0 : POS_W'(POS_LIMIT) - w_qty;
            w_buy_sz = (w_room < POS_W'(w_bid_sz)) ? w_room[7:0] : w_bid_sz;
            w_buy_ok = (w_buy_sz != '0);
        end
`else
        w_buy_sz = w_bid_sz;
        w_buy_ok = 1'b1;
`endif
    end

    // Trade word for the latched message.
    always_comb begin
        w_trade = '0;
        if (w_type == 2'b01 && w_off_px > w_sell_th && r_hit && w_qty != '0)
            w_trade = {2'b10, w_sym, w_off_px, w_sell_sz, {(PX_W + 8){1'b0}}};
        else if (w_type == 2'b10 && w_bid_px < w_buy_th && (r_hit || r_has_free) && w_buy_ok)
            w_trade = {2'b01, w_sym, {(PX_W + 8){1'b0}}, w_bid_px, w_buy_sz};
    end

    // Table write for confirms: update on hit, allocate on miss, drop when full.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_hit_idx;
        w_drop   = 1'b0;
        if (r_state == ST_DECIDE && w_type == 2'b11) begin
            if (r_hit) begin
                w_wr_en = 1'b1;
            end else if (w_off_sz != '0) begin
                if (r_has_free) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_free_idx;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
        w_set_ovf = (r_state == ST_DECIDE) && (w_type == 2'b11) && (w_underflow || w_drop);
    end

    // Registered trade word and sticky overflow flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_trade <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == ST_DECIDE) r_trade <= w_trade;
            if (w_set_ovf)            r_ovf   <= 1'b1;
        end
    end

    // Symbol table; a slot whose quantity reaches zero is freed.
    // NOTE: the table is a flop array with async reset so every slot starts invalid; a RAM could not be cleared like this.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_valid <= '0;
            for (int i = 0; i < N_SYM; i++) begin
                r_sym[i] <= '0;
                r_qty[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_valid[w_wr_idx] <= (w_qty_new != '0);
            r_sym[w_wr_idx]   <= w_sym;
            r_qty[w_wr_idx]   <= w_qty_new;
        end
    end

    // Count of valid slots.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < N_SYM; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
    end

    assign trade_o     = r_trade;
    assign overflow_o  = r_ovf;
    assign occupancy_o = w_occ;

endmodule

// File: tb/tb_trade_decision_multi.sv
// Self-checking bench for trade_decision_multi: directed plan steps followed by
// randomized messages compared against a behavioural symbol-table model.
// TRADE_DEC_POS_LIMIT_EN selects the position-limit checks when defined.
module tb_trade_decision_multi;

    localparam int N_SYM     = 4;
    localparam int PX_W      = 64;
    localparam int THRESH    = 5;
    localparam int POS_W     = 8;
    localparam int POS_LIMIT = 200;
    localparam int MSG_W     = 2 + 32 + 2 * PX_W + 16;
`ifdef TRADE_DEC_POS_LIMIT_EN
    localparam int QCAP = POS_LIMIT;
`else
    localparam int QCAP = 255;
`endif

    logic             clk = 1'b0;
    logic             reset_n_i;
    logic [MSG_W-1:0] message_i;
    logic [PX_W-1:0]  average_i;
    logic             v_i, ready_o, yumi_i, v_o;
    logic [MSG_W-1:0] trade_o;
    logic [2:0]       occupancy_o;
    logic             overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit          m_valid [N_SYM];
    logic [31:0] m_sym   [N_SYM];
    int          m_qty   [N_SYM];
    bit          m_ovf;

    trade_decision_multi #(
        .N_SYM(N_SYM), .PX_W(PX_W), .THRESH(THRESH), .POS_W(POS_W), .POS_LIMIT(POS_LIMIT)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .message_i(message_i), .average_i(average_i),
        .v_i(v_i), .ready_o(ready_o), .yumi_i(yumi_i), .v_o(v_o), .trade_o(trade_o),
        .occupancy_o(occupancy_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N_SYM; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_SYM; i++) begin
            m_valid[i] = 0;
            m_sym[i]   = '0;
            m_qty[i]   = 0;
        end
        m_ovf = 0;
    endtask

    // Applies one message to the model and returns the trade word it should produce.
    task automatic model_step(input logic [1:0] t, input logic [31:0] sym,
                              input logic [63:0] bpx, input logic [7:0] bsz,
                              input logic [63:0] opx, input logic [7:0] osz,
                              input logic [63:0] avg, output logic [MSG_W-1:0] exp);
        int hit, free, qty, n, size, bs, os;
        logic [64:0] bth, sth;
        hit = -1; free = -1; exp = '0;
        bs = int'(bsz); os = int'(osz);
        for (int i = 0; i < N_SYM; i++) begin
            if (m_valid[i] && m_sym[i] == sym) hit = i;
            if (!m_valid[i] && free < 0) free = i;
        end
        qty = (hit >= 0) ? m_qty[hit] : 0;
        bth = (avg >= 64'(THRESH)) ? {1'b0, avg} - 65'(THRESH) : 65'd0;
        sth = {1'b0, avg} + 65'(THRESH);
        if (sth > 65'h0_FFFF_FFFF_FFFF_FFFF) sth = 65'h0_FFFF_FFFF_FFFF_FFFF;
        case (t)
            2'b01: if ({1'b0, opx} > sth && hit >= 0 && qty != 0) begin
                size = (qty < os) ? qty : os;
                exp  = {2'b10, sym, opx, 8'(size), 72'd0};
            end
            2'b10: if ({1'b0, bpx} < bth && (hit >= 0 || free >= 0)) begin
                size = bs;
`ifdef TRADE_DEC_POS_LIMIT_EN
                if (POS_LIMIT - qty < size) size = POS_LIMIT - qty;
                if (size < 0) size = 0;
                if (size > 0)
`endif
                exp = {2'b01, sym, 72'd0, bpx, 8'(size)};
            end
            2'b11: begin
                n = qty - bs + os;
                if (n < 0) begin m_ovf = 1; n = 0; end
                if (n > QCAP) n = QCAP;
                if (hit >= 0) begin
                    m_qty[hit] = n; m_valid[hit] = (n != 0);
                end else if (os != 0) begin
                    if (free >= 0) begin
                        m_sym[free] = sym; m_qty[free] = n; m_valid[free] = (n != 0);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, MSG_W'(ready_o), MSG_W'(1));
        check({tag, "_v_o"}, MSG_W'(v_o), MSG_W'(0));
        check({tag, "_trade"}, trade_o, '0);
        check({tag, "_occ"}, MSG_W'(occupancy_o), MSG_W'(0));
        check({tag, "_ovf"}, MSG_W'(overflow_o), MSG_W'(0));
    endtask

    // Called at #1 after a rising edge; leaves the bench at #1 after a rising edge.
    task automatic do_reset();
        reset_n_i = 1'b0;
        #1;
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        model_clear();
    endtask

    // One full message transaction with exact-cycle checks of the handshake.
    task automatic run_msg(input logic [1:0] t, input logic [31:0] sym,
                           input logic [63:0] bpx, input logic [7:0] bsz,
                           input logic [63:0] opx, input logic [7:0] osz,
                           input logic [63:0] avg, input int hold,
                           output logic [MSG_W-1:0] got);
        logic [MSG_W-1:0] exp;
        model_step(t, sym, bpx, bsz, opx, osz, avg, exp);
        message_i = {t, sym, bpx, bsz, opx, osz};
        average_i = avg;
        v_i = 1'b1;
        check("ready_in_wait", MSG_W'(ready_o), MSG_W'(1));
        @(posedge clk); #1;
        v_i = 1'b0;
        message_i = MSG_W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        average_i = {$urandom, $urandom};
        check("lookup_ready", MSG_W'(ready_o), MSG_W'(0));
        check("lookup_v_o", MSG_W'(v_o), MSG_W'(0));
        @(posedge clk); #1;
        check("decide_v_o", MSG_W'(v_o), MSG_W'(0));
        @(posedge clk); #1;
        check("done_v_o", MSG_W'(v_o), MSG_W'(1));
        check("trade", trade_o, exp);
        check("occupancy", MSG_W'(occupancy_o), MSG_W'(model_count()));
        check("overflow", MSG_W'(overflow_o), MSG_W'(m_ovf));
        got = trade_o;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_trade", trade_o, exp);
            check("hold_v_o", MSG_W'(v_o), MSG_W'(1));
            check("hold_ready", MSG_W'(ready_o), MSG_W'(0));
        end
        yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        check("after_yumi_v_o", MSG_W'(v_o), MSG_W'(0));
        check("after_yumi_ready", MSG_W'(ready_o), MSG_W'(1));
    endtask

    initial begin
        logic [MSG_W-1:0] got;
        logic [1:0]  t;
        logic [31:0] sym;
        logic [63:0] avg, bpx, opx;
        logic [7:0]  bsz, osz;
        int mode, d;

        reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
        message_i = '0; average_i = '0;
        model_clear();
        #2;
        check_reset_vals("por");
        @(posedge clk); #1;
        reset_n_i = 1'b1;

        // Buy just below threshold, then exactly at threshold.
        run_msg(2'b10, 32'hAAAA, 64'd94, 8'd10, 64'd0, 8'd0, 64'd100, 0, got);
        check("plan_buy", got, {2'b01, 32'hAAAA, 72'd0, 64'd94, 8'd10});
        run_msg(2'b10, 32'hAAAA, 64'd95, 8'd10, 64'd0, 8'd0, 64'd100, 0, got);
        check("plan_buy_at_th", got, '0);

        // Open a position, sell against it, close it.
        run_msg(2'b11, 32'hAAAA, 64'd0, 8'd0, 64'd0, 8'd10, 64'd100, 0, got);
        run_msg(2'b01, 32'hAAAA, 64'd0, 8'd0, 64'd106, 8'd25, 64'd100, 0, got);
        check("plan_sell", got, {2'b10, 32'hAAAA, 64'd106, 8'd10, 72'd0});
        check("plan_sell_occ", MSG_W'(occupancy_o), MSG_W'(1));
        run_msg(2'b11, 32'hAAAA, 64'd0, 8'd10, 64'd0, 8'd0, 64'd100, 0, got);
        check("plan_close_occ", MSG_W'(occupancy_o), MSG_W'(0));

        // Fill the table, overflow on a fifth symbol, no buy for it.
        for (int s = 1; s <= 4; s++)
            run_msg(2'b11, 32'(s), 64'd0, 8'd0, 64'd0, 8'd3, 64'd100, 0, got);
        run_msg(2'b11, 32'd5, 64'd0, 8'd0, 64'd0, 8'd3, 64'd100, 0, got);
        check("plan_full_ovf", MSG_W'(overflow_o), MSG_W'(1));
        check("plan_full_occ", MSG_W'(occupancy_o), MSG_W'(4));
        run_msg(2'b10, 32'd5, 64'd10, 8'd7, 64'd0, 8'd0, 64'd100, 0, got);
        check("plan_full_nobuy", got, '0);

        // Underflow clamp, then zero buy threshold.
        do_reset();
        run_msg(2'b11, 32'd1, 64'd0, 8'd0, 64'd0, 8'd3, 64'd100, 0, got);
        run_msg(2'b11, 32'd1, 64'd0, 8'd5, 64'd0, 8'd0, 64'd100, 0, got);
        check("plan_clamp_ovf", MSG_W'(overflow_o), MSG_W'(1));
        check("plan_clamp_occ", MSG_W'(occupancy_o), MSG_W'(0));
        run_msg(2'b10, 32'd2, 64'd0, 8'd4, 64'd0, 8'd0, 64'd3, 0, got);
        check("plan_zero_th", got, '0);

        // Stall in DONE for 10 cycles.
        do_reset();
        run_msg(2'b11, 32'hBEEF, 64'd0, 8'd0, 64'd0, 8'd40, 64'd50, 0, got);
        run_msg(2'b01, 32'hBEEF, 64'd0, 8'd0, 64'd60, 8'd7, 64'd50, 10, got);

        // Reset pulse while the next message is in LOOKUP.
        message_i = {2'b11, 32'hCAFE, 64'd0, 8'd0, 64'd0, 8'd9};
        average_i = 64'd50;
        v_i = 1'b1;
        @(posedge clk); #1;
        v_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check_reset_vals("mid_lookup");
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check_reset_vals("after_abort");

`ifdef TRADE_DEC_POS_LIMIT_EN
        do_reset();
        run_msg(2'b11, 32'h77, 64'd0, 8'd0, 64'd0, 8'd195, 64'd100, 0, got);
        run_msg(2'b10, 32'h77, 64'd10, 8'd20, 64'd0, 8'd0, 64'd100, 0, got);
        check("limit_buy5", got, {2'b01, 32'h77, 72'd0, 64'd10, 8'd5});
        run_msg(2'b11, 32'h77, 64'd0, 8'd0, 64'd0, 8'd30, 64'd100, 0, got);
        run_msg(2'b10, 32'h77, 64'd10, 8'd20, 64'd0, 8'd0, 64'd100, 0, got);
        check("limit_full", got, '0);
`endif

        // Randomized traffic over a small symbol pool.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            t    = 2'($urandom_range(0, 3));
            sym  = 32'h100 + 32'($urandom_range(0, 5));
            mode = $urandom_range(0, 3);
            if (mode == 0)      avg = 64'($urandom_range(0, 10));
            else if (mode == 3) avg = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 10));
            else                avg = 64'($urandom_range(100, 1000));
            d   = $urandom_range(0, 16);
            bpx = avg + 64'(d - 8);
            d   = $urandom_range(0, 16);
            opx = avg + 64'(d - 8);
            bsz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
            osz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
            run_msg(t, sym, bpx, bsz, opx, osz, avg, $urandom_range(0, 2), got);
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
